sort_vec_serializer: RTL and testbench
======================================

Name: sort_vec_serializer

Overview:
- Consumer end of the sort_top output interface.
- Captures each parallel sorted vector on sorted/valid_out and buffers it in a small vector FIFO, because sort_top has no backpressure.
- Streams the vectors out one element per cycle on a valid/ready scalar stream, with an end-of-vector marker.
- Sits between sort_top and any narrow downstream consumer (UART, DMA, scoreboard port).

Parameters:
- WIDTH, 32: element width in bits; elements are signed two's complement.
- DEPTH, 8: elements per vector; must be a power of two and at least 2.
- FIFO_DEPTH, 4: vector entries buffered; must be at least 1.
- DESCENDING, 0: when 1, elements are emitted from index DEPTH-1 down to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- vec_valid  in  1  one-cycle strobe from sort_top valid_out; may be high on consecutive cycles.
- vec_data  in  DEPTH x WIDTH signed  sorted vector, index 0 smallest.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accept.
- m_data  out  WIDTH signed  current element.
- m_last  out  1  high with the final element of a vector.
- m_index  out  $clog2(DEPTH)  position of the current element in emission order (0..DEPTH-1).
- fill  out  $clog2(FIFO_DEPTH+1)  number of vectors stored, including the one being emitted.
- overflow  out  1  sticky flag: a vector was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO emptied; write/read pointers, element counter and fill set to 0.
  - m_valid=0, m_last=0, m_index=0, overflow=0.
  - m_data is don't-care but must drive 0.
  - Storage array is not reset.
- Push:
  - On a posedge with vec_valid=1, vec_data is written to the tail entry if fill<FIFO_DEPTH, or if fill==FIFO_DEPTH and the head's last element is popped in the same cycle.
  - Otherwise the vector is dropped, overflow is set to 1, and FIFO state is unchanged.
- Output:
  - m_valid = (fill!=0), driven from registered state only; no combinational path from vec_valid or m_ready to m_valid.
  - m_data = head[k], where k = elem_cnt, or DEPTH-1-elem_cnt when DESCENDING=1.
  - m_index = elem_cnt; m_last = m_valid and (elem_cnt==DEPTH-1).
- Pop:
  - A handshake occurs when m_valid and m_ready are both 1 at a posedge; elem_cnt then increments.
  - On the handshake with m_last=1: elem_cnt wraps to 0, the read pointer advances (modulo FIFO_DEPTH) and the head entry frees.
- Latency: a vector pushed at posedge N has its first element on m_data after N when the FIFO was empty, i.e. m_valid is high in cycle N+1.
- Throughput: one element per cycle while m_ready=1. Sustained input rate must not exceed 1 vector per DEPTH cycles; faster input overflows once the FIFO is full.
- m_ready low: m_data, m_index and m_last hold stable; elem_cnt holds.
- Simultaneous push and final pop:
  - fill is unchanged.
  - With FIFO_DEPTH=1, the new vector is written into the freed entry and the next cycle presents its element 0.
- Pointers are $clog2(FIFO_DEPTH)-bit with explicit wrap; they must be correct for non-power-of-two FIFO_DEPTH.
- overflow:
  - Set on a drop, cleared by ovf_clr=1.
  - A drop in the same cycle as ovf_clr leaves overflow at 1 (set has priority).
- Reset mid-vector: the partially emitted vector is discarded; after reset release there is no m_valid until a new push.
- Controller state machine:
  - IDLE: fill==0.
  - STREAM: fill>0.
  - IDLE->STREAM on push; STREAM->IDLE on a last pop with fill==1 and no simultaneous push.

Decomposition:
- sort_pkg holds:
  - default WIDTH and DEPTH localparams;
  - typedef elem_t (signed WIDTH);
  - typedef vec_t (elem_t array of DEPTH);
  - function clog2_min1 (returns at least 1).
- sort_top and the bench share these types.
- One sub-module, sort_vec_fifo: a parameterised vec_t FIFO with push/pop/full/empty/count.
- The serializer adds the element counter, output mux and overflow logic around it.

Test Plan:
- Single vector {-10,-3,-1,0,2,4,5,7}, m_ready=1:
  - m_valid from cycle N+1 for 8 cycles;
  - m_data sequence -10..7;
  - m_last only with 7; m_index 0..7; fill 1 then 0.
- DESCENDING=1, vector {-2147483648,-123,-1,0,0,1,123,2147483647}:
  - emits 2147483647 first and -2147483648 last, with m_last on -2147483648.
- Backpressure: same ascending vector, m_ready low on alternate cycles:
  - all 8 elements in order, none duplicated or skipped;
  - m_data stable while stalled; 16 cycles total.
- Overflow: FIFO_DEPTH=4, m_ready=0, six back-to-back vec_valid pulses:
  - fill=4, overflow=1;
  - releasing m_ready yields exactly the first 4 vectors (32 elements);
  - ovf_clr then drives overflow to 0.
- Push coincident with last pop at fill==FIFO_DEPTH:
  - vector accepted, fill unchanged, overflow stays 0;
  - the next vector starts on the cycle after m_last.
- Reset asserted after 3 elements emitted:
  - m_valid=0 and fill=0 immediately (asynchronous);
  - after release, no output until a new vector {7,7,7,7,7,7,7,7}, which then streams 8 sevens.

Source files
------------

// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort_pkg
//  Description : Shared element/vector types, default geometry and helpers
//                for the sort datapath and its consumers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sort_pkg;

  localparam int SORT_WIDTH = 32;
  localparam int SORT_DEPTH = 8;

  // One signed element and one full sorted vector (index 0 smallest).
  typedef logic signed [SORT_WIDTH-1:0] elem_t;
  typedef elem_t vec_t [SORT_DEPTH];

  // Serializer controller states.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ctrl_state_t;

  // Address width that never collapses to zero bits (depth 1 still needs a pointer).
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sort_vec_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sort_vec_fifo
//  Description : Whole-vector FIFO. Each entry holds one flattened vector so
//                a vector is pushed or retired in a single cycle. The head
//                entry is read combinationally; storage is not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_vec_fifo
  import sort_pkg::*;
#(
  parameter int DATA_W     = SORT_WIDTH * SORT_DEPTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int               c_ptr_w    = clog2_min1(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  // Pointers wrap explicitly so non-power-of-two depths index correctly.
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_last) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cnt_full);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head retires in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Vector storage; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/sort_vec_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : sort_vec_serializer
//  Description : Buffers parallel sorted vectors from sort_top (which cannot
//                be stalled) and streams them one element per cycle on a
//                valid/ready port with an end-of-vector marker. Vectors that
//                arrive with no room are dropped and flagged in a sticky bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_vec_serializer
  import sort_pkg::*;
#(
  parameter int WIDTH      = SORT_WIDTH,
  parameter int DEPTH      = SORT_DEPTH,
  parameter int FIFO_DEPTH = 4,
  parameter bit DESCENDING = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              vec_valid,
  input  logic signed [WIDTH-1:0]           vec_data [DEPTH],
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic signed [WIDTH-1:0]           m_data,
  output logic                              m_last,
  output logic [$clog2(DEPTH)-1:0]          m_index,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill,
  output logic                              overflow,
  input  logic                              ovf_clr
);

  localparam int c_idx_w  = $clog2(DEPTH);
  localparam int c_fill_w = $clog2(FIFO_DEPTH + 1);
  localparam int c_flat_w = WIDTH * DEPTH;
  localparam logic [c_idx_w-1:0]  c_idx_last = c_idx_w'(DEPTH - 1);
  localparam logic [c_fill_w-1:0] c_fill_one = c_fill_w'(1);

  ctrl_state_t             r_state;
  logic [c_idx_w-1:0]      r_elem_cnt;
  logic                    r_overflow;

  logic [c_flat_w-1:0]     w_vec_flat;
  logic [c_flat_w-1:0]     w_head_flat;
  logic signed [WIDTH-1:0] w_head [DEPTH];
  logic [c_idx_w-1:0]      w_sel;
  logic                    w_full;
  logic                    w_empty;
  logic [c_fill_w-1:0]     w_fill;
  logic                    w_hs;
  logic                    w_last_pop;
  logic                    w_push;
  logic                    w_drop;

  // Flatten the incoming vector for storage and split the head back into lanes.
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    assign w_vec_flat[i*WIDTH +: WIDTH] = vec_data[i];
    assign w_head[i]                    = w_head_flat[i*WIDTH +: WIDTH];
  end

  // Emission order: storage index follows the element counter or its mirror.
  if (DESCENDING) begin : g_desc
    assign w_sel = c_idx_last - r_elem_cnt;
  end else begin : g_asc
    assign w_sel = r_elem_cnt;
  end

  // Handshake and admission. A push into a full FIFO is only taken when the
  // head vector's final element leaves on the same edge.
  assign w_hs       = m_valid && m_ready;
  assign w_last_pop = w_hs && m_last;
  assign w_push     = vec_valid && (!w_full || w_last_pop);
  assign w_drop     = vec_valid && !w_push;

  sort_vec_fifo #(
    .DATA_W     (c_flat_w),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (c_fill_w)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_vec_flat),
    .pop       (w_last_pop && !w_empty),
    .head_data (w_head_flat),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_fill)
  );

  // Outputs decode only registered state; m_data is forced to 0 when idle so
  // unreset storage never leaks onto the port.
  assign m_valid  = (r_state == ST_STREAM);
  assign m_index  = r_elem_cnt;
  assign m_last   = m_valid && (r_elem_cnt == c_idx_last);
  assign m_data   = m_valid ? w_head[w_sel] : '0;
  assign fill     = w_fill;
  assign overflow = r_overflow;

  // Controller: stream state, element counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_elem_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_push) r_state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (w_last_pop && (w_fill == c_fill_one) && !w_push) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_hs) r_elem_cnt <= m_last ? '0 : r_elem_cnt + 1'b1;

      // A drop wins over a simultaneous clear.
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_vec_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort_vec_serializer
//  Description : Self-checking bench for sort_vec_serializer (ascending and
//                descending instances) against a vector-queue reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_vec_serializer;
  import sort_pkg::*;

  localparam int c_fifo_depth = 4;

  logic clk;
  logic rst;

  logic       a_vv, a_rdy, a_clr;
  vec_t       a_vd;
  logic       a_mv, a_ml, a_ovf;
  elem_t      a_md;
  logic [2:0] a_mi, a_fill;

  logic       d_vv, d_rdy, d_clr;
  vec_t       d_vd;
  logic       d_mv, d_ml, d_ovf;
  elem_t      d_md;
  logic [2:0] d_mi, d_fill;

  int checks;
  int failures;

  // Reference: queue of accepted vectors, elements already sent from the head.
  vec_t mq[$];
  int   mpos;
  bit   movf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sort_vec_serializer #(.WIDTH(32), .DEPTH(8), .FIFO_DEPTH(c_fifo_depth), .DESCENDING(1'b0)) u_asc (
    .clk(clk), .rst(rst), .vec_valid(a_vv), .vec_data(a_vd), .m_valid(a_mv), .m_ready(a_rdy),
    .m_data(a_md), .m_last(a_ml), .m_index(a_mi), .fill(a_fill), .overflow(a_ovf), .ovf_clr(a_clr)
  );

  sort_vec_serializer #(.WIDTH(32), .DEPTH(8), .FIFO_DEPTH(c_fifo_depth), .DESCENDING(1'b1)) u_desc (
    .clk(clk), .rst(rst), .vec_valid(d_vv), .vec_data(d_vd), .m_valid(d_mv), .m_ready(d_rdy),
    .m_data(d_md), .m_last(d_ml), .m_index(d_mi), .fill(d_fill), .overflow(d_ovf), .ovf_clr(d_clr)
  );

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < SORT_DEPTH; i++) v[i] = elem_t'($urandom);
    return v;
  endfunction

  // One clock on the ascending instance: update the reference from the
  // inputs being applied, then advance to the next falling edge.
  task automatic cyc(input logic vv, input vec_t vd, input logic rdy, input logic clr);
    bit hs, lp, acc;
    hs  = (mq.size() != 0) && rdy;
    lp  = hs && (mpos == SORT_DEPTH - 1);
    acc = vv && ((mq.size() < c_fifo_depth) || lp);
    if (hs) begin
      if (lp) begin
        void'(mq.pop_front());
        mpos = 0;
      end else begin
        mpos++;
      end
    end
    if (acc) mq.push_back(vd);
    if (vv && !acc) movf = 1'b1;
    else if (clr)   movf = 1'b0;
    a_vv = vv; a_vd = vd; a_rdy = rdy; a_clr = clr;
    @(posedge clk);
    @(negedge clk);
    a_vv = 1'b0; a_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_vv = 0; a_rdy = 0; a_clr = 0; a_vd = '{default: 0};
    d_vv = 0; d_rdy = 0; d_clr = 0; d_vd = '{default: 0};
    mq.delete(); mpos = 0; movf = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_mv, a_ml, a_ovf, a_mi, a_fill} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl: mv=%0b ml=%0b ovf=%0b mi=%0d fill=%0d expected all 0", a_mv, a_ml, a_ovf, a_mi, a_fill);
    end
    checks++;
    if (a_md !== 32'sd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", a_md); end
    checks++;
    if ({d_mv, d_ovf, d_fill} !== 5'b0) begin
      failures++; $display("FAIL reset_desc: mv=%0b ovf=%0b fill=%0d expected 0", d_mv, d_ovf, d_fill);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_mv !== 1'b0) begin failures++; $display("FAIL reset_release_valid: got %0b expected 0", a_mv); end
  endtask

  task automatic test_single();
    vec_t v;
    v = '{-10, -3, -1, 0, 2, 4, 5, 7};
    cyc(1'b1, v, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_mv !== 1'b1 || a_md !== v[i] || a_mi !== 3'(i) || a_ml !== (i == 7) || a_fill !== 3'd1) begin
        failures++;
        $display("FAIL single_elem%0d: mv=%0b data=%0d idx=%0d last=%0b fill=%0d expected 1 %0d %0d %0b 1",
                 i, a_mv, a_md, a_mi, a_ml, a_fill, v[i], i, (i == 7));
      end
      cyc(1'b0, v, 1'b1, 1'b0);
    end
    checks++;
    if (a_mv !== 1'b0 || a_fill !== 3'd0) begin
      failures++; $display("FAIL single_end: mv=%0b fill=%0d expected 0 0", a_mv, a_fill);
    end
  endtask

  task automatic test_desc();
    vec_t v;
    v = '{32'sh8000_0000, -123, -1, 0, 0, 1, 123, 32'sh7fff_ffff};
    d_vv = 1'b1; d_vd = v; d_rdy = 1'b1;
    @(posedge clk); @(negedge clk);
    d_vv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (d_mv !== 1'b1 || d_md !== v[7-i] || d_mi !== 3'(i) || d_ml !== (i == 7)) begin
        failures++;
        $display("FAIL desc_elem%0d: mv=%0b data=%0d idx=%0d last=%0b expected 1 %0d %0d %0b",
                 i, d_mv, d_md, d_mi, d_ml, v[7-i], i, (i == 7));
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (d_mv !== 1'b0) begin failures++; $display("FAIL desc_end: mv=%0b expected 0", d_mv); end
  endtask

  task automatic test_backpressure();
    vec_t  v;
    int    k;
    elem_t prev;
    bit    stalled;
    v = '{-10, -3, -1, 0, 2, 4, 5, 7};
    k = 0; stalled = 0; prev = '0;
    cyc(1'b1, v, 1'b0, 1'b0);
    for (int t = 0; t < 16; t++) begin
      checks++;
      if (a_mv !== 1'b1 || a_md !== v[k] || a_mi !== 3'(k) || a_ml !== (k == 7)) begin
        failures++;
        $display("FAIL bp_cycle%0d: mv=%0b data=%0d idx=%0d last=%0b expected 1 %0d %0d %0b",
                 t, a_mv, a_md, a_mi, a_ml, v[k], k, (k == 7));
      end
      if (stalled) begin
        checks++;
        if (a_md !== prev) begin failures++; $display("FAIL bp_stable%0d: got %0d expected %0d", t, a_md, prev); end
      end
      prev = a_md;
      stalled = (t % 2 == 0);
      cyc(1'b0, v, (t % 2 == 1), 1'b0);
      if (t % 2 == 1) k++;
    end
    checks++;
    if (a_mv !== 1'b0) begin failures++; $display("FAIL bp_end: mv=%0b expected 0", a_mv); end
  endtask

  task automatic test_overflow();
    vec_t sent[6];
    for (int j = 0; j < 6; j++) begin
      sent[j] = rand_vec();
      cyc(1'b1, sent[j], 1'b0, 1'b0);
    end
    checks++;
    if (a_fill !== 3'd4 || a_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_full: fill=%0d ovf=%0b expected 4 1", a_fill, a_ovf);
    end
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (a_mv !== 1'b1 || a_md !== sent[e/8][e%8] || a_ml !== (e % 8 == 7)) begin
        failures++;
        $display("FAIL ovf_drain%0d: mv=%0b data=%0d last=%0b expected 1 %0d %0b",
                 e, a_mv, a_md, a_ml, sent[e/8][e%8], (e % 8 == 7));
      end
      cyc(1'b0, sent[0], 1'b1, 1'b0);
    end
    checks++;
    if (a_mv !== 1'b0 || a_fill !== 3'd0 || a_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_drained: mv=%0b fill=%0d ovf=%0b expected 0 0 1", a_mv, a_fill, a_ovf);
    end
    cyc(1'b0, sent[0], 1'b1, 1'b1);
    checks++;
    if (a_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %0b expected 0", a_ovf); end
  endtask

  task automatic test_coincident();
    vec_t w[5];
    for (int j = 0; j < 5; j++) w[j] = rand_vec();
    for (int j = 0; j < 4; j++) cyc(1'b1, w[j], 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, w[0], 1'b1, 1'b0);
    checks++;
    if (a_ml !== 1'b1 || a_md !== w[0][7] || a_fill !== 3'd4) begin
      failures++; $display("FAIL coinc_pre: last=%0b data=%0d fill=%0d expected 1 %0d 4", a_ml, a_md, a_fill, w[0][7]);
    end
    cyc(1'b1, w[4], 1'b1, 1'b0);
    checks++;
    if (a_fill !== 3'd4 || a_ovf !== 1'b0 || a_mv !== 1'b1 || a_mi !== 3'd0 || a_md !== w[1][0]) begin
      failures++;
      $display("FAIL coinc_post: fill=%0d ovf=%0b mv=%0b idx=%0d data=%0d expected 4 0 1 0 %0d",
               a_fill, a_ovf, a_mv, a_mi, a_md, w[1][0]);
    end
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (a_mv !== 1'b1 || a_md !== w[1+e/8][e%8]) begin
        failures++; $display("FAIL coinc_drain%0d: mv=%0b data=%0d expected 1 %0d", e, a_mv, a_md, w[1+e/8][e%8]);
      end
      cyc(1'b0, w[0], 1'b1, 1'b0);
    end
    checks++;
    if (a_mv !== 1'b0) begin failures++; $display("FAIL coinc_end: mv=%0b expected 0", a_mv); end
  endtask

  task automatic test_reset_mid();
    vec_t vr, v7;
    vr = rand_vec();
    v7 = '{default: 7};
    cyc(1'b1, vr, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, vr, 1'b1, 1'b0);
    checks++;
    if (a_mi !== 3'd3 || a_mv !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre: idx=%0d mv=%0b expected 3 1", a_mi, a_mv);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (a_mv !== 1'b0 || a_fill !== 3'd0) begin
      failures++; $display("FAIL rstmid_async: mv=%0b fill=%0d expected 0 0", a_mv, a_fill);
    end
    mq.delete(); mpos = 0; movf = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, vr, 1'b1, 1'b0);
      checks++;
      if (a_mv !== 1'b0) begin failures++; $display("FAIL rstmid_idle%0d: mv=%0b expected 0", i, a_mv); end
    end
    cyc(1'b1, v7, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (a_mv !== 1'b1 || a_md !== 32'sd7 || a_mi !== 3'(i) || a_ml !== (i == 7)) begin
        failures++;
        $display("FAIL rstmid_seven%0d: mv=%0b data=%0d idx=%0d last=%0b expected 1 7 %0d %0b",
                 i, a_mv, a_md, a_mi, a_ml, i, (i == 7));
      end
      cyc(1'b0, v7, 1'b1, 1'b0);
    end
    checks++;
    if (a_mv !== 1'b0) begin failures++; $display("FAIL rstmid_end: mv=%0b expected 0", a_mv); end
  endtask

  task automatic test_random();
    bit    ev;
    elem_t ed;
    for (int t = 0; t < 440; t++) begin
      ev = (mq.size() != 0);
      checks++;
      if (a_mv !== ev || a_fill !== 3'(mq.size()) || a_ovf !== movf ||
          a_mi !== 3'(mpos) || a_ml !== (ev && mpos == 7)) begin
        failures++;
        $display("FAIL rand_ctrl%0d: mv=%0b fill=%0d ovf=%0b idx=%0d last=%0b expected %0b %0d %0b %0d %0b",
                 t, a_mv, a_fill, a_ovf, a_mi, a_ml, ev, mq.size(), movf, mpos, (ev && mpos == 7));
      end
      if (ev) begin
        ed = mq[0][mpos];
        checks++;
        if (a_md !== ed) begin failures++; $display("FAIL rand_data%0d: got %0d expected %0d", t, a_md, ed); end
      end
      if (t < 400)
        cyc(($urandom_range(0, 5) == 0), rand_vec(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      else
        cyc(1'b0, rand_vec(), 1'b1, 1'b0);
    end
    checks++;
    if (a_mv !== 1'b0 || a_fill !== 3'd0) begin
      failures++; $display("FAIL rand_end: mv=%0b fill=%0d expected 0 0", a_mv, a_fill);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_desc();
    test_backpressure();
    test_overflow();
    test_coincident();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
